// File: rtl/warp_pkg.sv
`default_nettype none
// ============================================================================
// warp_pkg : shared constants and types for the warp scan controller
// Rev 1.0
// ============================================================================
package warp_pkg;

  localparam int C_H_RES_DEF      = 640;
  localparam int C_V_RES_DEF      = 480;
  localparam int C_FIFO_DEPTH_DEF = 16;

  localparam int C_COORD_W = 10;
  localparam int C_R_W     = 5;
  localparam int C_G_W     = 6;
  localparam int C_B_W     = 5;
  localparam int C_PIX_W   = C_R_W + C_G_W + C_B_W;

  localparam logic [1:0] C_ST_IDLE  = 2'd0;
  localparam logic [1:0] C_ST_SCAN  = 2'd1;
  localparam logic [1:0] C_ST_DRAIN = 2'd2;
  localparam logic [1:0] C_ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = C_ST_IDLE,
    S_SCAN  = C_ST_SCAN,
    S_DRAIN = C_ST_DRAIN,
    S_DONE  = C_ST_DONE
  } state_t;

  typedef logic [C_COORD_W-1:0] coord_t;

  typedef struct packed {
    logic [C_R_W-1:0] r;
    logic [C_G_W-1:0] g;
    logic [C_B_W-1:0] b;
  } pixel_t;

endpackage
`default_nettype wire

// File: rtl/warp_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// warp_scan_ctrl_if : homography request/return and display-side bus
// Rev 1.0
// ============================================================================
interface warp_scan_ctrl_if;
  import warp_pkg::*;

  logic                 iFRAME_GO;
  coord_t               oX;
  coord_t               oY;
  logic                 oSTART;
  coord_t               iCON_X;
  coord_t               iCON_Y;
  logic [C_R_W-1:0]     iR;
  logic [C_G_W-1:0]     iG;
  logic [C_B_W-1:0]     iB;
  logic                 iREADY;
  logic                 iDISP_REQ;
  logic [C_R_W-1:0]     oDISP_R;
  logic [C_G_W-1:0]     oDISP_G;
  logic [C_B_W-1:0]     oDISP_B;
  logic                 oDISP_VALID;
  logic                 oFIFO_EMPTY;
  logic                 oBUSY;
  logic                 oFRAME_DONE;
  logic                 oSEQ_ERR;

  modport master (
    input  iFRAME_GO, iCON_X, iCON_Y, iR, iG, iB, iREADY, iDISP_REQ,
    output oX, oY, oSTART, oDISP_R, oDISP_G, oDISP_B, oDISP_VALID,
           oFIFO_EMPTY, oBUSY, oFRAME_DONE, oSEQ_ERR
  );

  modport slave (
    output iFRAME_GO, iCON_X, iCON_Y, iR, iG, iB, iREADY, iDISP_REQ,
    input  oX, oY, oSTART, oDISP_R, oDISP_G, oDISP_B, oDISP_VALID,
           oFIFO_EMPTY, oBUSY, oFRAME_DONE, oSEQ_ERR
  );

endinterface
`default_nettype wire

// File: rtl/warp_fifo.sv
`default_nettype none
// ============================================================================
// warp_fifo : single-clock pixel FIFO with occupancy count
// Rev 1.0
// ============================================================================
module warp_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16
) (
  input  logic                   iCLK,
  input  logic                   iRST,
  input  logic                   iPush,
  input  logic                   iPop,
  input  logic [WIDTH-1:0]       iWrData,
  output logic [WIDTH-1:0]       oRdData,
  output logic [$clog2(DEPTH):0] oCount,
  output logic                   oEmpty,
  output logic                   oFull
);

  localparam int              C_AW   = $clog2(DEPTH);
  localparam logic [C_AW:0]   C_FULL = (C_AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [C_AW-1:0]  r_wrPtr;
  logic [C_AW-1:0]  r_rdPtr;
  logic [C_AW:0]    r_count;
  logic             w_bypass;
  logic             w_doPush;
  logic             w_doPop;

  assign oEmpty = (r_count == '0);
  assign oFull  = (r_count == C_FULL);
  assign oCount = r_count;

  // Push and pop together on an empty FIFO hand the write data straight through
  assign w_bypass = iPush & iPop & oEmpty;
  assign w_doPush = iPush & ~w_bypass & (~oFull | iPop);
  assign w_doPop  = iPop & ~oEmpty;
  assign oRdData  = oEmpty ? iWrData : r_mem[r_rdPtr];

  always_ff @(posedge iCLK) begin
    if (w_doPush) r_mem[r_wrPtr] <= iWrData;
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/warp_scan_ctrl.sv
`default_nettype none
// ============================================================================
// warp_scan_ctrl : raster request generator, return-order checker, display FIFO
// Rev 1.0
// ============================================================================
module warp_scan_ctrl
  import warp_pkg::*;
#(
  parameter int H_RES      = C_H_RES_DEF,
  parameter int V_RES      = C_V_RES_DEF,
  parameter int FIFO_DEPTH = C_FIFO_DEPTH_DEF
) (
  input  logic              iCLK,
  input  logic              iRST,
  warp_scan_ctrl_if.master  bus
);

  localparam int            C_CW     = $clog2(FIFO_DEPTH) + 1;
  localparam coord_t        C_X_LAST = coord_t'(H_RES - 1);
  localparam coord_t        C_Y_LAST = coord_t'(V_RES - 1);
  localparam logic [C_CW:0] C_DEPTH  = (C_CW + 1)'(FIFO_DEPTH);

  state_t          r_state;
  coord_t          r_scanX;
  coord_t          r_scanY;
  coord_t          r_expX;
  coord_t          r_expY;
  coord_t          r_x;
  coord_t          r_y;
  logic [C_CW-1:0] r_outst;
  logic            r_start;
  logic            r_frameDone;
  logic            r_seqErr;
  logic            r_dispValid;
  pixel_t          r_disp;

  logic [C_CW-1:0] w_fifoCount;
  logic            w_fifoEmpty;
  logic            w_fifoFull;
  pixel_t          w_fifoRd;
  pixel_t          w_pixIn;
  logic            w_ready;
  logic            w_retire;
  logic            w_issue;
  logic            w_pop;
  logic            w_overflow;
  logic            w_mismatch;

  // Returns are only meaningful while a frame is in flight; late ones are dropped
  assign w_ready    = bus.iREADY & ((r_state == S_SCAN) | (r_state == S_DRAIN));
  assign w_retire   = w_ready & (r_outst != '0);
  assign w_issue    = (r_state == S_SCAN) &
                      (({1'b0, r_outst} + {1'b0, w_fifoCount}) < C_DEPTH);
  assign w_pixIn    = {bus.iR, bus.iG, bus.iB};
  assign w_pop      = bus.iDISP_REQ & (~w_fifoEmpty | w_ready);
  assign w_overflow = w_ready & w_fifoFull & ~bus.iDISP_REQ;
  assign w_mismatch = w_ready & ((bus.iCON_X != r_expX) | (bus.iCON_Y != r_expY));

  warp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (C_PIX_W)
  ) u_fifo (
    .iCLK    (iCLK),
    .iRST    (iRST),
    .iPush   (w_ready),
    .iPop    (w_pop),
    .iWrData (w_pixIn),
    .oRdData (w_fifoRd),
    .oCount  (w_fifoCount),
    .oEmpty  (w_fifoEmpty),
    .oFull   (w_fifoFull)
  );

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state     <= S_IDLE;
      r_scanX     <= '0;
      r_scanY     <= '0;
      r_expX      <= '0;
      r_expY      <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_outst     <= '0;
      r_start     <= 1'b0;
      r_frameDone <= 1'b0;
      r_seqErr    <= 1'b0;
      r_dispValid <= 1'b0;
      r_disp      <= '0;
    end else begin
      r_start     <= 1'b0;
      r_frameDone <= 1'b0;
      r_dispValid <= w_pop;
      if (w_pop) r_disp <= w_fifoRd;

      if (w_issue && !w_retire)      r_outst <= r_outst + 1'b1;
      else if (!w_issue && w_retire) r_outst <= r_outst - 1'b1;

      if (w_ready) begin
        if (w_mismatch || w_overflow) r_seqErr <= 1'b1;
        if (r_expX == C_X_LAST) begin
          r_expX <= '0;
          r_expY <= (r_expY == C_Y_LAST) ? '0 : r_expY + 1'b1;
        end else begin
          r_expX <= r_expX + 1'b1;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (bus.iFRAME_GO) begin
            r_state  <= S_SCAN;
            r_scanX  <= '0;
            r_scanY  <= '0;
            r_expX   <= '0;
            r_expY   <= '0;
            r_outst  <= '0;
            r_seqErr <= 1'b0;
          end
        end
        S_SCAN: begin
          if (w_issue) begin
            r_start <= 1'b1;
            r_x     <= r_scanX;
            r_y     <= r_scanY;
            if (r_scanX == C_X_LAST) begin
              r_scanX <= '0;
              if (r_scanY == C_Y_LAST) r_state <= S_DRAIN;
              else                     r_scanY <= r_scanY + 1'b1;
            end else begin
              r_scanX <= r_scanX + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (r_outst == '0 && w_fifoEmpty) begin
            r_state     <= S_DONE;
            r_frameDone <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.oX          = r_x;
  assign bus.oY          = r_y;
  assign bus.oSTART      = r_start;
  assign bus.oDISP_R     = r_disp.r;
  assign bus.oDISP_G     = r_disp.g;
  assign bus.oDISP_B     = r_disp.b;
  assign bus.oDISP_VALID = r_dispValid;
  assign bus.oFIFO_EMPTY = w_fifoEmpty;
  assign bus.oBUSY       = (r_state != S_IDLE);
  assign bus.oFRAME_DONE = r_frameDone;
  assign bus.oSEQ_ERR    = r_seqErr;

endmodule
`default_nettype wire

// File: tb/tb_warp_scan_ctrl.sv
`default_nettype none
// ============================================================================
// tb_warp_scan_ctrl : directed bench with a 3-cycle homography echo model
// Rev 1.0
// ============================================================================
module tb_warp_scan_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  warp_scan_ctrl_if bus ();

  warp_scan_ctrl #(
    .H_RES      (4),
    .V_RES      (2),
    .FIFO_DEPTH (4)
  ) dut (
    .iCLK (clk),
    .iRST (rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int          nChecks  = 0;
  int          nErrors  = 0;
  int          cyc      = 0;
  int          doneCnt  = 0;
  bit          swapFirst = 1'b0;
  int          qX[$];
  int          qY[$];
  int          qDue[$];
  logic [19:0] startLog[$];
  logic [15:0] dispLog[$];

  function automatic logic [15:0] pix(int x, int y);
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
    r = 5'(x + 4 * y + 1);
    g = 6'(x * 8 + y);
    b = 5'(31 - x - 4 * y);
    return {r, g, b};
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    nChecks++;
    assert (obs === exp)
    else begin
      nErrors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: observe settled outputs, then drive the echo model's return
  task automatic tick();
    int t;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.oSTART === 1'b1) begin
      startLog.push_back({bus.oY, bus.oX});
      qX.push_back(int'(bus.oX));
      qY.push_back(int'(bus.oY));
      qDue.push_back(cyc + 3);
      if (swapFirst && qX.size() == 2) begin
        t = qX[0]; qX[0] = qX[1]; qX[1] = t;
        t = qY[0]; qY[0] = qY[1]; qY[1] = t;
        swapFirst = 1'b0;
      end
    end
    if (bus.oDISP_VALID === 1'b1) dispLog.push_back({bus.oDISP_R, bus.oDISP_G, bus.oDISP_B});
    if (bus.oFRAME_DONE === 1'b1) doneCnt++;
    if (qDue.size() > 0 && qDue[0] <= cyc) begin
      bus.iREADY = 1'b1;
      bus.iCON_X = 10'(qX[0]);
      bus.iCON_Y = 10'(qY[0]);
      {bus.iR, bus.iG, bus.iB} = pix(qX[0], qY[0]);
      void'(qX.pop_front());
      void'(qY.pop_front());
      void'(qDue.pop_front());
    end else begin
      bus.iREADY = 1'b0;
    end
  endtask

  task automatic go();
    bus.iFRAME_GO = 1'b1;
    tick();
    bus.iFRAME_GO = 1'b0;
  endtask

  task automatic clearLogs();
    startLog.delete();
    dispLog.delete();
  endtask

  task automatic runUntilDone(string tag, int budget);
    int d0 = doneCnt;
    int n  = 0;
    while (doneCnt == d0 && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_done_seen"}, 32'(doneCnt - d0), 32'd1);
    repeat (2) tick();
    check({tag, "_done_once"}, 32'(doneCnt - d0), 32'd1);
    check({tag, "_idle"}, 32'(bus.oBUSY), 32'd0);
  endtask

  task automatic checkFrame(string tag);
    check({tag, "_nstart"}, 32'(startLog.size()), 32'd8);
    check({tag, "_ndisp"}, 32'(dispLog.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < startLog.size())
        check($sformatf("%s_start%0d", tag, i), 32'(startLog[i]), 32'({10'(i / 4), 10'(i % 4)}));
      if (i < dispLog.size())
        check($sformatf("%s_pix%0d", tag, i), 32'(dispLog[i]), 32'(pix(i % 4, i / 4)));
    end
  endtask

  initial begin
    bus.iFRAME_GO = 1'b0;
    bus.iCON_X    = '0;
    bus.iCON_Y    = '0;
    bus.iR        = '0;
    bus.iG        = '0;
    bus.iB        = '0;
    bus.iREADY    = 1'b0;
    bus.iDISP_REQ = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_x", 32'(bus.oX), 32'd0);
    check("rst_y", 32'(bus.oY), 32'd0);
    check("rst_start", 32'(bus.oSTART), 32'd0);
    check("rst_dvalid", 32'(bus.oDISP_VALID), 32'd0);
    check("rst_empty", 32'(bus.oFIFO_EMPTY), 32'd1);
    check("rst_busy", 32'(bus.oBUSY), 32'd0);
    check("rst_done", 32'(bus.oFRAME_DONE), 32'd0);
    check("rst_seqerr", 32'(bus.oSEQ_ERR), 32'd0);
    rst = 1'b0;
    tick();

    // Nominal frame with the display always pulling
    bus.iDISP_REQ = 1'b1;
    clearLogs();
    go();
    check("nom_busy", 32'(bus.oBUSY), 32'd1);
    repeat (5) tick();
    check("nom_outst_stall", 32'(dut.r_outst), 32'd3);
    check("nom_start_stall", 32'(bus.oSTART), 32'd0);
    tick();
    check("nom_start_resume", 32'(bus.oSTART), 32'd1);
    check("nom_xy_resume", 32'({bus.oY, bus.oX}), 32'({10'd1, 10'd0}));
    check("nom_outst_both", 32'(dut.r_outst), 32'd3);
    check("nom_count_both", 32'(dut.w_fifoCount), 32'd0);
    runUntilDone("nom", 60);
    checkFrame("nom");
    check("nom_seqerr", 32'(bus.oSEQ_ERR), 32'd0);
    check("nom_empty", 32'(bus.oFIFO_EMPTY), 32'd1);

    // Back-pressure: display stalled, then released
    bus.iDISP_REQ = 1'b0;
    clearLogs();
    go();
    repeat (12) tick();
    check("bp_nstart", 32'(startLog.size()), 32'd4);
    check("bp_count", 32'(dut.w_fifoCount), 32'd4);
    check("bp_outst", 32'(dut.r_outst), 32'd0);
    check("bp_start", 32'(bus.oSTART), 32'd0);
    check("bp_empty", 32'(bus.oFIFO_EMPTY), 32'd0);
    check("bp_busy", 32'(bus.oBUSY), 32'd1);
    bus.iDISP_REQ = 1'b1;
    runUntilDone("bp", 60);
    checkFrame("bp");
    check("bp_seqerr", 32'(bus.oSEQ_ERR), 32'd0);

    // Push+pop at full, then overflow with the display stalled
    bus.iDISP_REQ = 1'b0;
    clearLogs();
    go();
    repeat (12) tick();
    check("full_count_pre", 32'(dut.w_fifoCount), 32'd4);
    bus.iREADY    = 1'b1;
    bus.iCON_X    = 10'd0;
    bus.iCON_Y    = 10'd1;
    {bus.iR, bus.iG, bus.iB} = pix(0, 1);
    bus.iDISP_REQ = 1'b1;
    tick();
    bus.iDISP_REQ = 1'b0;
    check("full_pp_count", 32'(dut.w_fifoCount), 32'd4);
    check("full_pp_dvalid", 32'(bus.oDISP_VALID), 32'd1);
    check("full_pp_pix", 32'({bus.oDISP_R, bus.oDISP_G, bus.oDISP_B}), 32'(pix(0, 0)));
    check("full_pp_seqerr", 32'(bus.oSEQ_ERR), 32'd0);
    bus.iREADY    = 1'b1;
    bus.iCON_X    = 10'd1;
    bus.iCON_Y    = 10'd1;
    {bus.iR, bus.iG, bus.iB} = pix(1, 1);
    tick();
    check("ovf_count", 32'(dut.w_fifoCount), 32'd4);
    check("ovf_seqerr", 32'(bus.oSEQ_ERR), 32'd1);
    check("ovf_dvalid", 32'(bus.oDISP_VALID), 32'd0);
    bus.iDISP_REQ = 1'b1;
    runUntilDone("ovf", 60);
    check("ovf_seqerr_sticky", 32'(bus.oSEQ_ERR), 32'd1);

    // Misordered returns: (1,0) comes back before (0,0)
    clearLogs();
    swapFirst = 1'b1;
    go();
    check("mis_seqerr_cleared", 32'(bus.oSEQ_ERR), 32'd0);
    runUntilDone("mis", 60);
    check("mis_seqerr", 32'(bus.oSEQ_ERR), 32'd1);
    repeat (3) tick();
    check("mis_seqerr_hold", 32'(bus.oSEQ_ERR), 32'd1);

    // Reset mid-frame after five requests, then late returns
    clearLogs();
    go();
    check("rmf_seqerr_cleared", 32'(bus.oSEQ_ERR), 32'd0);
    for (int n = 0; n < 20 && startLog.size() < 5; n++) tick();
    check("rmf_nstart", 32'(startLog.size()), 32'd5);
    rst = 1'b1;
    #1;
    check("rmf_x", 32'(bus.oX), 32'd0);
    check("rmf_y", 32'(bus.oY), 32'd0);
    check("rmf_busy", 32'(bus.oBUSY), 32'd0);
    check("rmf_empty", 32'(bus.oFIFO_EMPTY), 32'd1);
    check("rmf_outst", 32'(dut.r_outst), 32'd0);
    check("rmf_dvalid", 32'(bus.oDISP_VALID), 32'd0);
    bus.iDISP_REQ = 1'b0;
    tick();
    rst = 1'b0;
    repeat (6) tick();
    check("late_count", 32'(dut.w_fifoCount), 32'd0);
    check("late_seqerr", 32'(bus.oSEQ_ERR), 32'd0);
    check("late_busy", 32'(bus.oBUSY), 32'd0);
    check("late_start", 32'(bus.oSTART), 32'd0);
    check("late_dvalid", 32'(bus.oDISP_VALID), 32'd0);

    // Clean frame after reset; a second iFRAME_GO mid-scan must be ignored
    bus.iDISP_REQ = 1'b1;
    clearLogs();
    go();
    tick();
    bus.iFRAME_GO = 1'b1;
    tick();
    bus.iFRAME_GO = 1'b0;
    runUntilDone("post", 60);
    checkFrame("post");
    check("post_seqerr", 32'(bus.oSEQ_ERR), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/warp_scan_ctrl.md
WARP_SCAN_CTRL -- requirements
Module: warp_scan_ctrl

Interface
REQ-001 Parameter H_RES, default 640: output frame width in pixels.
REQ-002 Parameter V_RES, default 480: output frame height in lines.
REQ-003 Parameter FIFO_DEPTH, default 16: pixel FIFO entries, power of two.
REQ-004 iCLK  input  1  sole clock; one clock domain, all state on rising edge.
REQ-005 iRST  input  1  reset, asynchronous, active-high.
REQ-006 iFRAME_GO  input  1  one-cycle pulse requesting one frame scan.
REQ-007 oX, oY  output  10 each  destination coordinate to the homography stage.
REQ-008 oSTART  output  1  one-cycle request qualifying oX/oY.
REQ-009 iCON_X, iCON_Y  input  10 each  coordinate echoed back with a returned pixel.
REQ-010 iR, iB  input  5 each; iG  input  6  returned RGB565 pixel.
REQ-011 iREADY  input  1  qualifies iCON_X/iCON_Y/iR/iG/iB for one cycle.
REQ-012 iDISP_REQ  input  1  display-side pop request.
REQ-013 oDISP_R, oDISP_B  output  5 each; oDISP_G  output  6  popped pixel.
REQ-014 oDISP_VALID  output  1  qualifies oDISP_* for one cycle.
REQ-015 oFIFO_EMPTY  output  1  FIFO holds zero entries.
REQ-016 oBUSY  output  1  state is not IDLE.
REQ-017 oFRAME_DONE  output  1  one-cycle pulse at frame completion.
REQ-018 oSEQ_ERR  output  1  sticky flag for out-of-order return or overflow.

Function
REQ-019 States SHALL be IDLE, SCAN, DRAIN, DONE; IDLE->SCAN on iFRAME_GO; iFRAME_GO outside IDLE is ignored.
REQ-020 Accepting iFRAME_GO SHALL clear scan counters, expected-return counters and oSEQ_ERR.
REQ-021 In SCAN, oSTART SHALL assert when (outstanding + fifo_count) < FIFO_DEPTH, with oX/oY registered in the same cycle.
REQ-022 Scan order SHALL be raster: oX 0..H_RES-1, then oX wraps to 0 and oY increments; one request per cycle maximum.
REQ-023 After issuing (H_RES-1, V_RES-1), the block SHALL go SCAN->DRAIN with no further oSTART.
REQ-024 Outstanding counter (log2(FIFO_DEPTH)+1 bits) SHALL increment on oSTART, decrement on iREADY, and hold when both occur in the same cycle.
REQ-025 On iREADY, the pixel {iR,iG,iB} SHALL be pushed into the FIFO.
REQ-026 A push while full SHALL be dropped and SHALL set oSEQ_ERR.
REQ-027 On iREADY, iCON_X/iCON_Y SHALL be compared to the expected raster position; a mismatch SHALL set oSEQ_ERR; the expected position advances on every iREADY.
REQ-028 iDISP_REQ with the FIFO non-empty SHALL pop one entry; oDISP_* and oDISP_VALID SHALL be registered (latency 1 cycle).
REQ-029 iDISP_REQ on an empty FIFO SHALL be ignored, with oDISP_VALID=0 and oDISP_* holding.
REQ-030 A push and a pop in the same cycle SHALL both occur, including when full or empty, leaving the count unchanged.
REQ-031 DRAIN->DONE SHALL occur when outstanding==0 and the FIFO is empty; DONE SHALL assert oFRAME_DONE for one cycle and then go to IDLE.
REQ-032 oFIFO_EMPTY and oBUSY SHALL be registered or derived only from registers, with no combinational path from inputs.

Reset
REQ-033 iRST SHALL asynchronously force IDLE and zero all counters and the FIFO pointers.
REQ-034 iRST SHALL also force oX=oY=0, oSTART=0, oDISP_*=0, oDISP_VALID=0, oFRAME_DONE=0, oSEQ_ERR=0, oBUSY=0 and oFIFO_EMPTY=1.
REQ-035 Reset asserted mid-frame SHALL abandon the frame; iREADY pulses arriving after reset release and before the next iFRAME_GO SHALL be dropped and SHALL NOT set oSEQ_ERR.

Structure
REQ-036 A shared package warp_pkg SHALL hold H_RES/V_RES defaults, RGB565 field widths, the coordinate width (10) and the state encoding constants.
REQ-037 The FIFO SHALL be a sub-module warp_fifo (synchronous, single clock, count output); the scan FSM, counters and compare logic stay in warp_scan_ctrl.

Verification
REQ-038 Bench SHALL run with H_RES=4, V_RES=2, FIFO_DEPTH=4 and a 3-cycle echo model of the homography stage.
REQ-039 Nominal frame: iFRAME_GO, iDISP_REQ held 1 -> 8 oSTART pulses in order (0,0)..(3,1), 8 oDISP_VALID pixels matching the model, one oFRAME_DONE, oSEQ_ERR=0.
REQ-040 Back-pressure: iDISP_REQ=0 -> oSTART stops after 4 requests with fifo_count=4; releasing iDISP_REQ resumes the scan with no loss.
REQ-041 Misorder: model returns (1,0) before (0,0) -> oSEQ_ERR=1 and stays set until the next accepted iFRAME_GO.
REQ-042 Simultaneous events: push+pop at full, and oSTART+iREADY in the same cycle -> fifo_count and outstanding unchanged.
REQ-043 Reset mid-frame after 5 requests, then late iREADYs -> outputs at reset values, no push, oSEQ_ERR=0; the next iFRAME_GO completes a clean frame.
